// File: rtl/ahb_sram_slave.sv
// AHB-Lite single-port SRAM slave with programmable wait states.
// Misaligned, out-of-range and illegal-size transfers get a two-cycle ERROR.
module ahb_sram_slave #(
  parameter int          MEM_WORDS_LOG2 = 10,
  parameter int          WAIT_STATES    = 1,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [31:0] HWDATA,
  output logic [31:0] HRDATA,
  output logic        HREADY,
  output logic [1:0]  HRESP
);

  localparam int DEPTH = 1 << MEM_WORDS_LOG2;
  localparam int HI    = MEM_WORDS_LOG2 + 2;

  localparam logic [1:0] OKAY  = 2'b00;
  localparam logic [1:0] ERROR = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t                    state;
  state_t                    nxt;
  logic [3:0]                cnt;
  logic [MEM_WORDS_LOG2-1:0] idx_q;
  logic [3:0]                be_q;
  logic                      wr_q;
  logic                      hready_q;
  logic [1:0]                hresp_q;
  logic [31:0]               mem [DEPTH];

  logic       take;
  logic       bad_size;
  logic       bad_align;
  logic       bad_range;
  logic       err;
  logic [3:0] be;

  assign take      = hready_q & HSEL & HTRANS[1];
  assign bad_size  = HSIZE > 3'b010;
  assign bad_align = (HSIZE == 3'b001 && HADDR[0]) ||
                     (HSIZE == 3'b010 && HADDR[1:0] != 2'b00);
  assign bad_range = HADDR[31:HI] != BASE_ADDR[31:HI];
  assign err       = bad_size | bad_align | bad_range;

  always_comb begin
    be = 4'b0000;
    unique case (1'b1)
      HSIZE == 3'b000: be = 4'b0001 << HADDR[1:0];
      HSIZE == 3'b001: be = HADDR[1] ? 4'b1100 : 4'b0011;
      default:         be = 4'b1111;
    endcase
  end

  // State entered from any cycle that can accept an address phase
  always_comb begin
    nxt = S_IDLE;
    if (take) begin
      if (err)
        nxt = S_ERR1;
      else if (WAIT_STATES == 0)
        nxt = S_DATA;
      else
        nxt = S_WAIT;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx_q    <= '0;
      be_q     <= '0;
      wr_q     <= 1'b0;
      hready_q <= 1'b1;
      hresp_q  <= OKAY;
    end else begin
      unique case (state)
        S_WAIT: begin
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state    <= S_DATA;
            hready_q <= 1'b1;
          end
        end
        S_ERR1: begin
          state    <= S_ERR2;
          hready_q <= 1'b1;
          hresp_q  <= ERROR;
        end
        default: begin
          state    <= nxt;
          hready_q <= !(nxt == S_WAIT || nxt == S_ERR1);
          hresp_q  <= (nxt == S_ERR1) ? ERROR : OKAY;
          if (take) begin
            idx_q <= HADDR[HI-1:2];
            be_q  <= be;
            wr_q  <= HWRITE;
            cnt   <= 4'(WAIT_STATES);
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_DATA && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (be_q[b])
          mem[idx_q][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA = (state == S_DATA && !wr_q) ? mem[idx_q] : '0;
  assign HREADY = hready_q;
  assign HRESP  = hresp_q;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: a zero-wait and a two-wait instance,
// driven by a pipelined master with a scoreboard of expected data phases.
module tb_ahb_sram_slave;

  localparam logic [1:0] ID = 2'b00;
  localparam logic [1:0] BS = 2'b01;
  localparam logic [1:0] NS = 2'b10;
  localparam logic [1:0] SQ = 2'b11;
  localparam logic [2:0] B  = 3'b000;
  localparam logic [2:0] H  = 3'b001;
  localparam logic [2:0] W  = 3'b010;

  typedef struct {
    logic        sel;
    logic [1:0]  trans;
    logic [31:0] addr;
    logic        wr;
    logic [2:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [31:0] mask;
    logic        err;
  } xfer_t;

  logic        clk = 1'b0;
  logic        rst    [2];
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [31:0] hwdata [2];
  logic [31:0] hrdata [2];
  logic        hready [2];
  logic [1:0]  hresp  [2];

  xfer_t items[$];
  xfer_t sb[$];
  int    tests = 0;
  int    fails = 0;

  always #5 clk = ~clk;

  ahb_sram_slave #(.MEM_WORDS_LOG2(10), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(rst[0]), .HSEL(hsel[0]), .HADDR(haddr[0]),
    .HTRANS(htrans[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]),
    .HWDATA(hwdata[0]), .HRDATA(hrdata[0]), .HREADY(hready[0]),
    .HRESP(hresp[0])
  );

  ahb_sram_slave #(.MEM_WORDS_LOG2(10), .WAIT_STATES(2)) dut1 (
    .clk(clk), .reset(rst[1]), .HSEL(hsel[1]), .HADDR(haddr[1]),
    .HTRANS(htrans[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]),
    .HWDATA(hwdata[1]), .HRDATA(hrdata[1]), .HREADY(hready[1]),
    .HRESP(hresp[1])
  );

  task automatic add(input logic sel, input logic [1:0] tr,
                     input logic [31:0] a, input logic wr,
                     input logic [2:0] sz, input logic [31:0] wd,
                     input logic [31:0] ex, input logic [31:0] mk,
                     input logic er);
    xfer_t x;
    x.sel = sel; x.trans = tr; x.addr = a; x.wr = wr; x.size = sz;
    x.wdata = wd; x.exp = ex; x.mask = mk; x.err = er;
    items.push_back(x);
  endtask

  task automatic drive_addr(input int d);
    if (items.size() > 0) begin
      hsel[d]   = items[0].sel;
      htrans[d] = items[0].trans;
      haddr[d]  = items[0].addr;
      hwrite[d] = items[0].wr;
      hsize[d]  = items[0].size;
    end else begin
      hsel[d]   = 1'b0;
      htrans[d] = ID;
      haddr[d]  = '0;
      hwrite[d] = 1'b0;
      hsize[d]  = B;
    end
  endtask

  // Must be entered just after a rising edge
  task automatic run_seq(input int d, input string name, input int ws);
    xfer_t       cur;
    int          waits;
    int          cyc;
    logic        rdy;
    logic [1:0]  rsp;
    logic [31:0] rd;
    waits = 0;
    cyc   = 0;
    drive_addr(d);
    while ((items.size() > 0 || sb.size() > 0) && cyc < 200) begin
      @(negedge clk);
      rdy = hready[d];
      rsp = hresp[d];
      rd  = hrdata[d];
      if (sb.size() > 0) begin
        cur = sb[0];
        tests++;
        if (rsp !== (cur.err ? 2'b01 : 2'b00)) begin
          fails++;
          $display("FAIL %s hresp dut%0d addr=%h got %b want %b",
                   name, d, cur.addr, rsp, cur.err ? 2'b01 : 2'b00);
        end
        if (!rdy) begin
          waits++;
          tests++;
          if (rd !== 32'h0) begin
            fails++;
            $display("FAIL %s hrdata_wait dut%0d addr=%h got %h want 0",
                     name, d, cur.addr, rd);
          end
        end else begin
          void'(sb.pop_front());
          tests++;
          if (waits != (cur.err ? 1 : ws)) begin
            fails++;
            $display("FAIL %s waits dut%0d addr=%h got %0d want %0d",
                     name, d, cur.addr, waits, cur.err ? 1 : ws);
          end
          tests++;
          if (!cur.wr && !cur.err) begin
            if ((rd & cur.mask) !== (cur.exp & cur.mask)) begin
              fails++;
              $display("FAIL %s rdata dut%0d addr=%h got %h want %h mask %h",
                       name, d, cur.addr, rd, cur.exp, cur.mask);
            end
          end else if (rd !== 32'h0) begin
            fails++;
            $display("FAIL %s hrdata_nonread dut%0d addr=%h got %h want 0",
                     name, d, cur.addr, rd);
          end
          waits = 0;
        end
      end else begin
        tests++;
        if (rdy !== 1'b1 || rsp !== 2'b00) begin
          fails++;
          $display("FAIL %s idle dut%0d got hready=%b hresp=%b want 1/00",
                   name, d, rdy, rsp);
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      if (rdy && items.size() > 0) begin
        cur = items.pop_front();
        if (cur.sel && cur.trans[1]) begin
          sb.push_back(cur);
          hwdata[d] = cur.wdata;
        end
        drive_addr(d);
      end
    end
    if (cyc >= 200) begin
      tests++;
      fails++;
      $display("FAIL %s timeout dut%0d got %0d cycles want <200", name, d, cyc);
      items.delete();
      sb.delete();
      drive_addr(d);
    end
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      hwdata[d] = '0;
      drive_addr(d);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      tests++;
      if (hready[d] !== 1'b1) begin
        fails++;
        $display("FAIL reset_hready dut%0d got %b want 1", d, hready[d]);
      end
      tests++;
      if (hresp[d] !== 2'b00) begin
        fails++;
        $display("FAIL reset_hresp dut%0d got %b want 00", d, hresp[d]);
      end
      tests++;
      if (hrdata[d] !== 32'h0) begin
        fails++;
        $display("FAIL reset_hrdata dut%0d got %h want 0", d, hrdata[d]);
      end
      rst[d] = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_ws0_rw();
    add(1, NS, 32'h10, 1, W, 32'hDEADBEEF, 0, 0, 0);
    add(1, NS, 32'h10, 0, W, 0, 32'hDEADBEEF, '1, 0);
    run_seq(0, "ws0_rw", 0);
  endtask

  task automatic test_byte_ws2();
    add(1, NS, 32'h20, 1, W, 32'h11223344, 0, 0, 0);
    add(1, NS, 32'h21, 1, B, 32'h0000AB00, 0, 0, 0);
    add(1, NS, 32'h20, 0, W, 0, 32'h1122AB44, '1, 0);
    run_seq(1, "byte_ws2", 2);
  endtask

  task automatic test_half(input int d, input int ws);
    add(1, NS, 32'h30, 1, W, 32'hA1B2C3D4, 0, 0, 0);
    add(1, NS, 32'h32, 1, H, 32'h55660000, 0, 0, 0);
    add(1, NS, 32'h32, 0, H, 0, 32'h55660000, 32'hFFFF0000, 0);
    add(1, NS, 32'h30, 0, W, 0, 32'h5566C3D4, '1, 0);
    add(1, NS, 32'h30, 1, H, 32'h00007788, 0, 0, 0);
    add(1, NS, 32'h33, 1, B, 32'h9A000000, 0, 0, 0);
    add(1, NS, 32'h30, 0, W, 0, 32'h9A667788, '1, 0);
    run_seq(d, "half", ws);
  endtask

  task automatic test_errors(input int d, input int ws);
    add(1, NS, 32'h40, 1, W, 32'h13579BDF, 0, 0, 0);
    add(1, NS, 32'h00, 1, W, 32'h2468ACE0, 0, 0, 0);
    add(1, NS, 32'h42, 0, W, 0, 0, 0, 1);
    add(1, NS, 32'h42, 1, W, 32'hFFFFFFFF, 0, 0, 1);
    add(1, NS, 32'h40, 1, 3'b011, 32'hFFFFFFFF, 0, 0, 1);
    add(1, NS, 32'h41, 1, H, 32'hFFFFFFFF, 0, 0, 1);
    add(1, NS, 32'h1000, 1, W, 32'hFFFFFFFF, 0, 0, 1);
    add(1, NS, 32'h1000, 0, W, 0, 0, 0, 1);
    add(1, NS, 32'h40, 0, W, 0, 32'h13579BDF, '1, 0);
    add(1, NS, 32'h00, 0, W, 0, 32'h2468ACE0, '1, 0);
    run_seq(d, "errors", ws);
  endtask

  task automatic test_idle_seq(input int d, input int ws);
    add(1, NS, 32'h60, 1, W, 32'h0F0F0F0F, 0, 0, 0);
    add(1, ID, 32'h60, 1, W, 32'hFFFFFFFF, 0, 0, 0);
    add(1, BS, 32'h60, 1, W, 32'hFFFFFFFF, 0, 0, 0);
    add(0, NS, 32'h60, 1, W, 32'hFFFFFFFF, 0, 0, 0);
    add(1, SQ, 32'h64, 1, W, 32'hA5A5A5A5, 0, 0, 0);
    add(1, SQ, 32'h60, 0, W, 0, 32'h0F0F0F0F, '1, 0);
    add(0, SQ, 32'h64, 1, W, 32'h12345678, 0, 0, 0);
    add(1, NS, 32'h64, 0, W, 0, 32'hA5A5A5A5, '1, 0);
    run_seq(d, "idle_seq", ws);
  endtask

  task automatic test_reset_mid();
    add(1, NS, 32'h50, 1, W, 32'h00000000, 0, 0, 0);
    run_seq(1, "rst_pre", 2);
    hsel[1] = 1'b1; htrans[1] = NS; haddr[1] = 32'h50;
    hwrite[1] = 1'b1; hsize[1] = W;
    @(posedge clk);
    #1;
    hwdata[1] = 32'hCAFEF00D;
    drive_addr(1);
    @(negedge clk);
    tests++;
    if (hready[1] !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_wait hready got %b want 0", hready[1]);
    end
    rst[1] = 1'b1;
    #1;
    tests++;
    if (hready[1] !== 1'b1 || hresp[1] !== 2'b00 || hrdata[1] !== 32'h0) begin
      fails++;
      $display("FAIL rst_mid got hready=%b hresp=%b hrdata=%h want 1/00/0",
               hready[1], hresp[1], hrdata[1]);
    end
    @(posedge clk);
    @(negedge clk);
    rst[1] = 1'b0;
    @(posedge clk);
    #1;
    add(1, NS, 32'h50, 0, W, 0, 32'h00000000, '1, 0);
    run_seq(1, "rst_post", 2);
  endtask

  initial begin
    test_reset();
    test_ws0_rw();
    test_byte_ws2();
    test_half(0, 0);
    test_half(1, 2);
    test_errors(0, 0);
    test_errors(1, 2);
    test_idle_seq(0, 0);
    test_idle_seq(1, 2);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
